// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready requesters.
// A grant is held for one packet or MAX_BURST beats; the write beat is held in an output register.
//
//   state | meaning
//   IDLE  | no grant; pick the next requester round-robin from rr_ptr (1 cycle)
//   GRANT | one requester owns the write port until req_last or the burst cap
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       w_clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       full,
  output logic                       wd_en,
  output logic [DATA_W-1:0]          d_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               wd_en_q,    wd_en_d;
  logic [DATA_W-1:0]  d_in_q,     d_in_d;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W:0]     rr_sum;
  logic [IDX_W-1:0]   rr_idx;
  logic               slot_free;
  logic               accept;
  logic               burst_end;
  logic [DATA_W-1:0]  grant_data;
  logic [IDX_W-1:0]   grant_next;

  // Round-robin search: first valid requester at rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    rr_sum = '0;
    rr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
      if (rr_sum >= NUM_REQ_W) begin
        rr_sum = rr_sum - NUM_REQ_W;
      end
      rr_idx = rr_sum[IDX_W-1:0];
      if (!found && req_valid[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

  // The output register can take a new beat if empty or if the held beat leaves this edge.
  assign slot_free  = ~wd_en_q | ~full;
  assign grant_data = req_data[grant_id_q*DATA_W +: DATA_W];
  assign accept     = (state_q == GRANT) && req_valid[grant_id_q] && slot_free;
  assign burst_end  = accept && (req_last[grant_id_q] || (beat_cnt_q == LAST_BEAT));
  assign grant_next = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (rst && (state_q == GRANT) && slot_free) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    wd_en_d    = wd_en_q;
    d_in_d     = d_in_q;

    // A held beat blocked by full stays put; otherwise it drains.
    if (accept) begin
      wd_en_d = 1'b1;
      d_in_d  = grant_data;
    end else if (!(wd_en_q && full)) begin
      wd_en_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = winner;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (burst_end) begin
          state_d  = IDLE;
          rr_ptr_d = grant_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      wd_en_q    <= 1'b0;
      d_in_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      wd_en_q    <= wd_en_d;
      d_in_q     <= d_in_d;
    end
  end

  assign wd_en    = wd_en_q;
  assign d_in     = d_in_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a table of directed per-cycle vectors plus
// hand-written fairness and backpressure sequences.
module tb_fifo_wr_arbiter;

  logic        w_clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        full;
  logic        wd_en;
  logic [7:0]  d_in;
  logic [1:0]  grant_id;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] wr_log[$];

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .w_clk    (w_clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .full     (full),
    .wd_en    (wd_en),
    .d_in     (d_in),
    .grant_id (grant_id),
    .busy     (busy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  e_ready;
    logic        e_wd_en;
    logic [7:0]  e_d_in;
    logic [1:0]  e_grant;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                     input logic f, input logic [3:0] er, input logic ew, input logic [7:0] ed,
                     input logic [1:0] eg, input logic eb);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.last = l; x.full = f;
    x.e_ready = er; x.e_wd_en = ew; x.e_d_in = ed; x.e_grant = eg; x.e_busy = eb;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Log a FIFO write at the coming edge, then move to the next falling edge.
  task automatic next_cycle();
    if (rst === 1'b1 && wd_en === 1'b1 && full === 1'b0) wr_log.push_back(d_in);
    @(negedge w_clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0; full = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0; full = 1'b0;

    //   rst valid  data          last  full | ready wd din    gnt busy
    add(0, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);  // reset state
    add(1, 4'b0010, 32'h0000_1000, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0); // T1 arbitration cycle
    add(1, 4'b0010, 32'h0000_1000, 4'b0000, 0, 4'b0010, 0, 8'h00, 1, 1);
    add(1, 4'b0010, 32'h0000_1100, 4'b0000, 0, 4'b0010, 1, 8'h10, 1, 1);
    add(1, 4'b0010, 32'h0000_1200, 4'b0010, 0, 4'b0010, 1, 8'h11, 1, 1);
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 1, 8'h12, 1, 0);
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 0, 8'h12, 1, 0);
    add(1, 4'b1010, 32'h3000_1300, 4'b1010, 0, 4'b0000, 0, 8'h12, 1, 0); // rr_ptr=2 -> picks 3
    add(1, 4'b1010, 32'h3000_1300, 4'b1010, 0, 4'b1000, 0, 8'h12, 3, 1);
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 1, 8'h30, 3, 0);
    add(1, 4'b0100, 32'h0020_0000, 4'b0100, 0, 4'b0000, 0, 8'h30, 3, 0); // T4 wrap search 0,1,2
    add(1, 4'b0100, 32'h0020_0000, 4'b0100, 0, 4'b0100, 0, 8'h30, 2, 1);
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 1, 8'h20, 2, 0);
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 0, 8'h20, 2, 0);
    add(1, 4'b0001, 32'h0000_0040, 4'b0000, 0, 4'b0000, 0, 8'h20, 2, 0); // rr_ptr=3 -> picks 0
    add(1, 4'b0001, 32'h0000_0040, 4'b0000, 0, 4'b0001, 0, 8'h20, 0, 1);
    add(0, 4'b0001, 32'h0000_0041, 4'b0000, 0, 4'b0000, 1, 8'h40, 0, 1); // T5 reset mid-burst
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);
    add(1, 4'b1010, 32'h3000_1300, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0); // rr_ptr back to 0 -> picks 1
    add(1, 4'b0010, 32'h3000_1300, 4'b0000, 0, 4'b0010, 0, 8'h00, 1, 1);
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0010, 1, 8'h13, 1, 1); // T6 valid gap, grant kept
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0010, 0, 8'h13, 1, 1);
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0010, 0, 8'h13, 1, 1);
    add(1, 4'b0010, 32'h0000_1500, 4'b0010, 0, 4'b0010, 0, 8'h13, 1, 1);
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 1, 8'h15, 1, 0);

    repeat (2) @(posedge w_clk);
    @(negedge w_clk);

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; req_valid = vecs[k].valid; req_data = vecs[k].data;
      req_last = vecs[k].last; full = vecs[k].full;
      #1;
      chk($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(vecs[k].e_ready));
      chk($sformatf("v%0d wd_en", k),     32'(wd_en),     32'(vecs[k].e_wd_en));
      chk($sformatf("v%0d d_in", k),      32'(d_in),      32'(vecs[k].e_d_in));
      chk($sformatf("v%0d grant_id", k),  32'(grant_id),  32'(vecs[k].e_grant));
      chk($sformatf("v%0d busy", k),      32'(busy),      32'(vecs[k].e_busy));
      next_cycle();
    end

    // T2 fairness: 4-beat bursts 0,1,2,3,0 with one arbitration cycle between them.
    do_reset();
    req_valid = 4'b1111; req_data = 32'hA3A2_A1A0; req_last = '0; full = 1'b0;
    for (int c = 0; c < 25; c++) begin
      int g, pg;
      logic eb, ew;
      #1;
      eb = ((c % 5) != 0);
      g  = (c / 5) % 4;
      ew = (c > 0) && (((c - 1) % 5) != 0);
      pg = ((c - 1) / 5) % 4;
      chk($sformatf("t2 c%0d busy", c), 32'(busy), 32'(eb));
      chk($sformatf("t2 c%0d req_ready", c), 32'(req_ready), eb ? (32'd1 << g) : 32'd0);
      if (eb) chk($sformatf("t2 c%0d grant_id", c), 32'(grant_id), 32'(g));
      chk($sformatf("t2 c%0d wd_en", c), 32'(wd_en), 32'(ew));
      if (ew) chk($sformatf("t2 c%0d d_in", c), 32'(d_in), 32'(8'hA0 + pg));
      next_cycle();
    end

    // T3 backpressure: 0x22 held through 5 full cycles, written once, then 0x23.
    do_reset();
    wr_log.delete();
    req_valid = 4'b0001; req_data = 32'h22; req_last = '0; full = 1'b0;
    #1; chk("t3 arb busy", 32'(busy), 32'd0);
    next_cycle();
    #1;
    chk("t3 grant ready", 32'(req_ready), 32'b0001);
    chk("t3 grant wd_en", 32'(wd_en), 32'd0);
    next_cycle();
    req_data = 32'h23; req_last = 4'b0001; full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t3 full%0d wd_en", c), 32'(wd_en), 32'd1);
      chk($sformatf("t3 full%0d d_in", c), 32'(d_in), 32'h22);
      chk($sformatf("t3 full%0d req_ready", c), 32'(req_ready), 32'd0);
      next_cycle();
    end
    full = 1'b0;
    #1;
    chk("t3 release d_in", 32'(d_in), 32'h22);
    chk("t3 release req_ready", 32'(req_ready), 32'b0001);
    next_cycle();
    req_valid = '0; req_last = '0;
    #1;
    chk("t3 next wd_en", 32'(wd_en), 32'd1);
    chk("t3 next d_in", 32'(d_in), 32'h23);
    chk("t3 next busy", 32'(busy), 32'd0);
    next_cycle();
    #1;
    chk("t3 drained wd_en", 32'(wd_en), 32'd0);
    next_cycle();
    chk("t3 write count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      chk("t3 write0", 32'(wr_log[0]), 32'h22);
      chk("t3 write1", 32'(wr_log[1]), 32'h23);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
